// File: rtl/bnn_layer_sched.sv
// Layer scheduler for a binary FC layer: buffers one input vector, streams ROM weight chunks
// through a shared XNOR-popcount neuron, accumulates and thresholds each neuron's sum.
module bnn_layer_sched #(
    parameter int PW          = 8,
    parameter int NUM_CHUNKS  = 2,
    parameter int NUM_NEURONS = 2,
    parameter int NRN_LAT     = 2,
    localparam int ACC_W      = $clog2(PW*NUM_CHUNKS+1),
    localparam int AW         = $clog2(NUM_NEURONS*NUM_CHUNKS),
    localparam int YW         = $clog2(PW+1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PW-1:0]                in_data,
    output logic [AW-1:0]                w_addr,
    input  logic [PW-1:0]                w_rdata,
    input  logic [NUM_NEURONS*ACC_W-1:0] thresh,
    output logic                         nrn_en,
    output logic [PW-1:0]                nrn_w,
    output logic [PW-1:0]                nrn_x,
    input  logic [YW-1:0]                nrn_y,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_NEURONS-1:0]       out_data,
    output logic                         busy
);

    localparam int CW  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int NW  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int TOT = NUM_NEURONS * NUM_CHUNKS;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    logic [2:0]             state_q, state_d;
    logic                   in_ready_q, in_ready_d;
    logic [CW-1:0]          c_q, c_d;
    logic [NW-1:0]          n_q, n_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [NUM_NEURONS-1:0] out_data_q, out_data_d;
    logic [PW-1:0]          x_buf_q [NUM_CHUNKS];
    logic [PW-1:0]          x_buf_d [NUM_CHUNKS];

    // Tag pipeline: stage 0 aligns with nrn_en, stage NRN_LAT with a valid nrn_y.
    logic                   tv_q [NRN_LAT+1];
    logic                   tv_d [NRN_LAT+1];
    logic [CW-1:0]          tc_q [NRN_LAT+1];
    logic [CW-1:0]          tc_d [NRN_LAT+1];
    logic [NW-1:0]          tn_q [NRN_LAT+1];
    logic [NW-1:0]          tn_d [NRN_LAT+1];
    logic                   tl_q [NRN_LAT+1];
    logic                   tl_d [NRN_LAT+1];

    logic [ACC_W-1:0]       sum;
    logic [ACC_W-1:0]       thr_sel;
    logic                   drain_done;

    assign drain_done = tv_q[NRN_LAT] && tl_q[NRN_LAT] &&
                        (tn_q[NRN_LAT] == NW'(NUM_NEURONS-1));

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        n_d      = n_q;
        addr_d   = addr_q;
        x_buf_d  = x_buf_q;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    x_buf_d[c_q] = in_data;
                    if (c_q == CW'(NUM_CHUNKS-1)) begin
                        c_d     = '0;
                        state_d = S_RUN;
                    end else begin
                        c_d     = c_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_RUN: begin
                if (c_q == CW'(NUM_CHUNKS-1)) begin
                    c_d = '0;
                    n_d = n_q + 1'b1;
                end else begin
                    c_d = c_q + 1'b1;
                end
                if (addr_q == AW'(TOT-1)) begin
                    addr_d  = '0;
                    n_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_DRAIN: if (drain_done) state_d = S_OUT;
            S_OUT:   if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    end

    always_comb begin
        tv_d[0] = (state_q == S_RUN);
        tc_d[0] = c_q;
        tn_d[0] = n_q;
        tl_d[0] = (c_q == CW'(NUM_CHUNKS-1));
        for (int i = 1; i <= NRN_LAT; i++) begin
            tv_d[i] = tv_q[i-1];
            tc_d[i] = tc_q[i-1];
            tn_d[i] = tn_q[i-1];
            tl_d[i] = tl_q[i-1];
        end
    end

    // The first chunk of a neuron restarts the sum, so no explicit clear is needed between neurons.
    always_comb begin
        acc_d      = acc_q;
        out_data_d = out_data_q;
        sum        = ((tc_q[NRN_LAT] == '0) ? '0 : acc_q) + ACC_W'(nrn_y);
        thr_sel    = '0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            if (tn_q[NRN_LAT] == NW'(n)) thr_sel = thresh[n*ACC_W +: ACC_W];
        end
        if (tv_q[NRN_LAT]) begin
            if (tl_q[NRN_LAT]) begin
                for (int n = 0; n < NUM_NEURONS; n++) begin
                    if (tn_q[NRN_LAT] == NW'(n)) out_data_d[n] = (sum >= thr_sel);
                end
                acc_d = '0;
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            c_q        <= '0;
            n_q        <= '0;
            addr_q     <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            for (int i = 0; i < NUM_CHUNKS; i++) x_buf_q[i] <= '0;
            for (int i = 0; i <= NRN_LAT; i++) begin
                tv_q[i] <= 1'b0;
                tc_q[i] <= '0;
                tn_q[i] <= '0;
                tl_q[i] <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            c_q        <= c_d;
            n_q        <= n_d;
            addr_q     <= addr_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            x_buf_q    <= x_buf_d;
            tv_q       <= tv_d;
            tc_q       <= tc_d;
            tn_q       <= tn_d;
            tl_q       <= tl_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign w_addr    = addr_q;
    assign nrn_en    = tv_q[0];
    assign nrn_w     = w_rdata;
    assign nrn_x     = x_buf_q[tc_q[0]];
    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_data_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bnn_layer_sched.sv
// Bench for bnn_layer_sched: sync weight ROM and XNOR-popcount neuron models around the DUT,
// a vector-level reference model, directed vectors with literal expectations.
module tb_bnn_layer_sched;

    localparam int PW    = 8;
    localparam int NC    = 2;
    localparam int NN    = 2;
    localparam int LAT   = 2;
    localparam int ACC_W = 5;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [PW-1:0]    in_data;
    logic [1:0]       w_addr;
    logic [PW-1:0]    w_rdata;
    logic [NN*ACC_W-1:0] thresh;
    logic             nrn_en;
    logic [PW-1:0]    nrn_w;
    logic [PW-1:0]    nrn_x;
    logic [3:0]       nrn_y;
    logic             out_valid;
    logic             out_ready;
    logic [NN-1:0]    out_data;
    logic             busy;

    logic [PW-1:0]    rom [NN*NC];
    logic [3:0]       y_pipe [LAT];
    logic [NN-1:0]    exp_data;
    logic             prev_ov;
    logic             prev_ordy;
    int               cyc = 0;
    int               checks = 0;
    int               failures = 0;

    bnn_layer_sched #(
        .PW(PW), .NUM_CHUNKS(NC), .NUM_NEURONS(NN), .NRN_LAT(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .w_addr(w_addr), .w_rdata(w_rdata), .thresh(thresh),
        .nrn_en(nrn_en), .nrn_w(nrn_w), .nrn_x(nrn_x), .nrn_y(nrn_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int popcnt(input logic [PW-1:0] v);
        int s = 0;
        for (int i = 0; i < PW; i++) s += int'(v[i]);
        return s;
    endfunction

    // Sync ROM and a neuron with LAT cycles from operand to popcount.
    always @(posedge clk) w_rdata <= rom[w_addr];

    always @(posedge clk) begin
        y_pipe[0] <= nrn_en ? 4'(popcnt(~(nrn_w ^ nrn_x))) : 4'd0;
        for (int i = 1; i < LAT; i++) y_pipe[i] <= y_pipe[i-1];
    end
    assign nrn_y = y_pipe[LAT-1];

    // Reference: each neuron's total matches count over the whole vector, compared to its threshold.
    function automatic logic [NN-1:0] model_out(input logic [PW*NC-1:0] x,
                                                input int t0, input int t1);
        logic [NN-1:0] r;
        int thr [NN];
        thr[0] = t0;
        thr[1] = t1;
        for (int n = 0; n < NN; n++) begin
            int s = 0;
            for (int c = 0; c < NC; c++) s += popcnt(~(rom[n*NC+c] ^ x[c*PW +: PW]));
            r[n] = (s >= thr[n]);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_in_ready"},  in_ready,  0);
        checkOutput({name, "_out_valid"}, out_valid, 0);
        checkOutput({name, "_out_data"},  out_data,  0);
        checkOutput({name, "_nrn_en"},    nrn_en,    0);
        checkOutput({name, "_w_addr"},    w_addr,    0);
        checkOutput({name, "_busy"},      busy,      0);
    endtask

    // Per-cycle compare while the output is presented, plus the valid-hold rule.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            checkOutput("cmp_out_data", out_data, exp_data);
            checkOutput("cmp_in_ready_low", in_ready, 0);
        end
        if (rst_n && prev_ov && !prev_ordy) checkOutput("cmp_valid_hold", out_valid, 1);
        prev_ov   <= rst_n && out_valid;
        prev_ordy <= out_ready;
    end

    // Sends one vector; returns at the negedge after the last handshake with lcyc = cycle L.
    task automatic applyStimulus(input logic [PW*NC-1:0] x, input int t0, input int t1,
                                 output int lcyc);
        int guard;
        thresh   = {ACC_W'(t1), ACC_W'(t0)};
        exp_data = model_out(x, t0, t1);
        lcyc     = 0;
        for (int c = 0; c < NC; c++) begin
            @(negedge clk);
            guard = 0;
            while (!in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) checkOutput("in_ready_timeout", in_ready, 1);
            in_valid = 1'b1;
            in_data  = x[c*PW +: PW];
            if (c == NC-1) lcyc = cyc;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic runVector(input string name, input logic [PW*NC-1:0] x,
                             input int t0, input int t1, input logic [NN-1:0] lit,
                             input bit hold_ready);
        int lcyc;
        int guard;
        out_ready = !hold_ready;
        applyStimulus(x, t0, t1, lcyc);
        checkOutput({name, "_model_pin"}, exp_data, lit);
        for (int k = 0; k < NN*NC; k++) begin
            checkOutput({name, "_w_addr"}, w_addr, k);
            if (k < NN*NC-1) @(negedge clk);
        end
        guard = 0;
        while (!out_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({name, "_out_valid_seen"}, out_valid, 1);
        checkOutput({name, "_latency"}, cyc - lcyc, 8);
        checkOutput({name, "_out_data"}, out_data, lit);
        if (hold_ready) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                checkOutput({name, "_hold_valid"}, out_valid, 1);
                checkOutput({name, "_hold_data"}, out_data, lit);
                checkOutput({name, "_hold_in_ready"}, in_ready, 0);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        checkOutput({name, "_valid_drop"}, out_valid, 0);
        checkOutput({name, "_in_ready_back"}, in_ready, 1);
        checkOutput({name, "_idle"}, busy, 0);
    endtask

    task automatic setRom(input logic [PW-1:0] r0, input logic [PW-1:0] r1,
                          input logic [PW-1:0] r2, input logic [PW-1:0] r3);
        rom[0] = r0;
        rom[1] = r1;
        rom[2] = r2;
        rom[3] = r3;
    endtask

    initial begin
        int lcyc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        thresh    = '0;
        exp_data  = '0;
        setRom(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_after_reset", in_ready, 1);

        runVector("all_ones",   16'hFFFF, 16, 16, 2'b11, 1'b0);
        runVector("over_max",   16'hFFFF, 16, 17, 2'b01, 1'b0);

        setRom(8'h00, 8'h00, 8'hFF, 8'hFF);
        runVector("split_w",    16'hFFFF, 1, 1, 2'b10, 1'b0);

        setRom(8'hFF, 8'hFE, 8'hFF, 8'hFE);
        runVector("sum9_t9_10", 16'h00FF, 9, 10, 2'b01, 1'b0);
        runVector("sum9_t0_9",  16'h00FF, 0, 9, 2'b11, 1'b0);
        runVector("sum9_t10_0", 16'h00FF, 10, 0, 2'b10, 1'b0);

        setRom(8'h3C, 8'h0F, 8'hF0, 8'h55);
        runVector("mixed",      16'hA5C3, 4, 9, 2'b01, 1'b0);
        runVector("backpress",  16'hA5C3, 8, 8, 2'b10, 1'b1);

        // Abort while the third address is on the bus; the next vector must start clean.
        setRom(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        applyStimulus(16'hFFFF, 16, 16, lcyc);
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort_w_addr", w_addr, 2);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("abort_in_reset");
        repeat (2) @(negedge clk);
        checkResetOutputs("abort_held");
        rst_n = 1'b1;
        setRom(8'hFF, 8'hFE, 8'hFF, 8'hFE);
        runVector("after_abort", 16'h00FF, 9, 10, 2'b01, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
